// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters,
// sequencing each operation through IDLE -> EXEC -> RESP with a tagged response.
module alu_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int OP_WIDTH   = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [OP_WIDTH-1:0]   req0_op,
   input  logic [DATA_WIDTH-1:0] req0_a,
   input  logic [DATA_WIDTH-1:0] req0_b,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [OP_WIDTH-1:0]   req1_op,
   input  logic [DATA_WIDTH-1:0] req1_a,
   input  logic [DATA_WIDTH-1:0] req1_b,
   output logic [OP_WIDTH-1:0]   alu_operation,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_zero,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_id,
   output logic [DATA_WIDTH-1:0] rsp_result,
   output logic                  rsp_zero,
   output logic                  busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_last_grant;
   logic                  r_grant_id;
   logic [OP_WIDTH-1:0]   r_op;
   logic [DATA_WIDTH-1:0] r_a;
   logic [DATA_WIDTH-1:0] r_b;
   logic                  r_rsp_valid;
   logic                  r_rsp_id;
   logic [DATA_WIDTH-1:0] r_rsp_result;
   logic                  r_rsp_zero;
   logic                  r_busy;

   logic                  w_grant;
   logic                  w_accept;

   always_comb begin
      // NOTE: default assignment first so every path drives w_grant and no latch is inferred.
      w_grant = 1'b0;
      if (req0_valid && req1_valid)
         w_grant = ~r_last_grant;   // tie goes to whoever did not win last
      else if (req1_valid)
         w_grant = 1'b1;
   end

   assign w_accept   = (r_state == S_IDLE) && (req0_valid || req1_valid);
   assign req0_ready = w_accept && !w_grant;
   assign req1_ready = w_accept &&  w_grant;

   assign alu_operation = r_op;
   assign alu_a         = r_a;
   assign alu_b         = r_b;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_id        = r_rsp_id;
   assign rsp_result    = r_rsp_result;
   assign rsp_zero      = r_rsp_zero;
   assign busy          = r_busy;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
      if (reset) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_grant_id   <= 1'b0;
         r_op         <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= 1'b0;
         r_rsp_result <= '0;
         r_rsp_zero   <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op         <= w_grant ? req1_op : req0_op;
                  r_a          <= w_grant ? req1_a  : req0_a;
                  r_b          <= w_grant ? req1_b  : req0_b;
                  r_grant_id   <= w_grant;
                  r_last_grant <= w_grant;
                  r_busy       <= 1'b1;
                  r_state      <= S_EXEC;
               end
            end
            S_EXEC: begin
               // ALU has had a full cycle to settle on the latched operands
               r_rsp_result <= alu_result;
               r_rsp_zero   <= alu_zero;
               r_rsp_id     <= r_grant_id;
               r_rsp_valid  <= 1'b1;
               r_state      <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_rsp_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU closing the loop.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req0_ready;
   logic [2:0]  req0_op;
   logic [31:0] req0_a, req0_b;
   logic        req1_valid, req1_ready;
   logic [2:0]  req1_op;
   logic [31:0] req1_a, req1_b;
   logic [2:0]  alu_operation;
   logic [31:0] alu_a, alu_b, alu_result;
   logic        alu_zero;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
   logic [31:0] rsp_result;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(3)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_operation(alu_operation), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
   );

   // Stand-in ALU: 110/111 are undefined and return 0
   always_comb begin
      case (alu_operation)
         3'b000:  alu_result = alu_a & alu_b;
         3'b001:  alu_result = alu_a | alu_b;
         3'b010:  alu_result = alu_a ^ alu_b;
         3'b011:  alu_result = alu_a + alu_b;
         3'b100:  alu_result = alu_a - alu_b;
         3'b101:  alu_result = alu_b << 16;
         default: alu_result = 32'd0;
      endcase
      alu_zero = (alu_result == 32'd0);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic set_req(input logic id, input logic v, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b);
      if (id) begin
         req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
      end else begin
         req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
      end
   endtask

   // Single-requester transaction with rsp_ready held high; returns at an IDLE negedge.
   task automatic run_op(input logic id, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic exp_zero, input string tag);
      int waited;
      @(negedge clk);
      set_req(id, 1'b1, op, a, b);
      #1;
      waited = 0;
      while (!(id ? req1_ready : req0_ready) && waited < 20) begin
         @(negedge clk); #1;
         waited++;
      end
      check({tag, "_ready"}, 32'(id ? req1_ready : req0_ready), 32'd1);
      check({tag, "_other_ready"}, 32'(id ? req0_ready : req1_ready), 32'd0);
      @(negedge clk);
      set_req(id, 1'b0, 3'd0, 32'd0, 32'd0);
      #1;
      check({tag, "_exec_busy"}, 32'(busy), 32'd1);
      check({tag, "_exec_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_exec_readies"}, 32'({req1_ready, req0_ready}), 32'd0);
      check({tag, "_alu_op"}, 32'(alu_operation), 32'(op));
      check({tag, "_alu_a"}, alu_a, a);
      check({tag, "_alu_b"}, alu_b, b);
      @(negedge clk); #1;
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_rsp_id"}, 32'(rsp_id), 32'(id));
      check({tag, "_rsp_result"}, rsp_result, exp_res);
      check({tag, "_rsp_zero"}, 32'(rsp_zero), 32'(exp_zero));
      @(negedge clk); #1;
      check({tag, "_post_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_post_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      rsp_ready = 1'b1;
      set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      set_req(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_readies", 32'({req1_ready, req0_ready}), 32'd0);
      check("rst_alu_op", 32'(alu_operation), 32'd0);
      check("rst_alu_a", alu_a, 32'd0);
      check("rst_alu_b", alu_b, 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_rsp_result", rsp_result, 32'd0);
      check("rst_rsp_zero", 32'(rsp_zero), 32'd0);

      run_op(1'b0, 3'b011, 32'd7, 32'd5, 32'd12, 1'b0, "add0");
      run_op(1'b0, 3'b110, 32'd5, 32'd3, 32'd0, 1'b1, "undef0");
      run_op(1'b1, 3'b100, 32'd9, 32'd9, 32'd0, 1'b1, "sub1");
      run_op(1'b1, 3'b101, 32'd0, 32'h0000ABCD, 32'hABCD0000, 1'b0, "shl1");

      // Both held valid: last grant was 1, so order must be 0,1,0,1
      @(negedge clk);
      set_req(1'b0, 1'b1, 3'b011, 32'd1, 32'd2);
      set_req(1'b1, 1'b1, 3'b100, 32'd10, 32'd3);
      #1;
      for (int k = 0; k < 4; k++) begin
         logic e;
         e = k[0];
         check($sformatf("rr%0d_ready0", k), 32'(req0_ready), 32'(!e));
         check($sformatf("rr%0d_ready1", k), 32'(req1_ready), 32'(e));
         @(negedge clk); #1;
         check($sformatf("rr%0d_exec_readies", k), 32'({req1_ready, req0_ready}), 32'd0);
         check($sformatf("rr%0d_alu_op", k), 32'(alu_operation), e ? 32'd4 : 32'd3);
         @(negedge clk); #1;
         check($sformatf("rr%0d_rsp_valid", k), 32'(rsp_valid), 32'd1);
         check($sformatf("rr%0d_rsp_id", k), 32'(rsp_id), 32'(e));
         check($sformatf("rr%0d_rsp_result", k), rsp_result, e ? 32'd7 : 32'd3);
         check($sformatf("rr%0d_resp_readies", k), 32'({req1_ready, req0_ready}), 32'd0);
         @(negedge clk); #1;
      end
      set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      set_req(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);

      // Back-pressure: req0 wins the tie (last grant 1), req1 waits out the stall
      @(negedge clk);
      rsp_ready = 1'b0;
      set_req(1'b0, 1'b1, 3'b010, 32'hF0, 32'hFF);
      set_req(1'b1, 1'b1, 3'b001, 32'h30, 32'h03);
      #1;
      check("bp_ready0", 32'(req0_ready), 32'd1);
      check("bp_ready1", 32'(req1_ready), 32'd0);
      @(negedge clk);
      set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         #1;
         check($sformatf("bp%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
         check($sformatf("bp%0d_rsp_id", i), 32'(rsp_id), 32'd0);
         check($sformatf("bp%0d_rsp_result", i), rsp_result, 32'h0F);
         check($sformatf("bp%0d_readies", i), 32'({req1_ready, req0_ready}), 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk); #1;
      check("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);
      check("bp_release_ready1", 32'(req1_ready), 32'd1);
      @(negedge clk);
      set_req(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
      @(negedge clk); #1;
      check("bp_next_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_next_rsp_id", 32'(rsp_id), 32'd1);
      check("bp_next_rsp_result", rsp_result, 32'h33);
      @(negedge clk); #1;
      check("bp_next_done", 32'(busy), 32'd0);

      // Reset during EXEC discards the op and restores the tie-break to req0
      @(negedge clk);
      set_req(1'b0, 1'b1, 3'b011, 32'd1, 32'd1);
      #1;
      check("rst_mid_ready0", 32'(req0_ready), 32'd1);
      @(negedge clk);
      set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      reset = 1'b1;
      #1;
      check("rst_mid_in_exec", 32'(busy), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      set_req(1'b0, 1'b1, 3'b011, 32'd2, 32'd2);
      set_req(1'b1, 1'b1, 3'b011, 32'd4, 32'd4);
      #1;
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_mid_alu_a", alu_a, 32'd0);
      check("rst_mid_rsp_result", rsp_result, 32'd0);
      check("rst_mid_grant0", 32'(req0_ready), 32'd1);
      check("rst_mid_grant1", 32'(req1_ready), 32'd0);
      set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      set_req(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         check($sformatf("rst_mid_quiet%0d", i), 32'(rsp_valid), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
